ram_arbiter2: RTL and testbench
===============================

Name: ram_arbiter2

Overview:
- Two-requester arbiter that shares one single-port RAM16K-style memory between two masters, e.g. the CPU data port (requester 0) and a screen-refresh/DMA engine (requester 1).
- Target memory has a combinational read and writes on the posedge of `clock` when its load input is high.
- The arbiter serialises accesses with a req/ack handshake, selects a winner (round-robin or fixed priority), drives the memory port, and returns registered read data.

Parameters:
- ADDR_W, 14, address width of the shared memory (16K words).
- DATA_W, 16, data word width.
- FIXED_PRI, 0, 0 = round-robin on contention; 1 = requester 0 always wins.

Ports:
- clock  in  1  system clock; all state changes on its posedge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 access request.
- load0  in  1  requester 0 write enable (1 = write, 0 = read).
- address0  in  ADDR_W  requester 0 word address.
- in0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- out0  out  DATA_W  requester 0 read data, valid while ack0 = 1.
- req1, load1, address1, in1, ack1, out1: same as requester 0, for requester 1.
- grant  out  2  one-hot current owner (bit i = requester i is in BUSY); 00 when idle.
- mem_load  out  1  memory write enable.
- mem_address  out  ADDR_W  memory address.
- mem_in  out  DATA_W  memory write data.
- mem_out  in  DATA_W  memory read data (combinational from mem_address).

Behaviour:
- Reset: asynchronous, active-high; clock and reset are the only timing inputs. While reset = 1 and after release:
  - state = IDLE, grant = 00, ack0 = ack1 = 0, out0 = out1 = 0.
  - last = 1, so requester 0 wins the first tie.
  - mem_load = 0 immediately (combinational from state); mem_address = 0, mem_in = 0.
- FSM states: IDLE, BUSY(sel), where sel is 0 or 1.
- IDLE:
  - eligible_i = req_i & ~ack_i. A requester's req is ignored in the cycle its ack is high.
  - No eligible requester: stay in IDLE.
  - Exactly one eligible: next state = BUSY(that requester).
  - Both eligible, FIXED_PRI = 1: requester 0 wins.
  - Both eligible, FIXED_PRI = 0: the requester not equal to last wins.
- BUSY(sel):
  - grant[sel] = 1.
  - mem_address = address_sel, mem_in = in_sel, mem_load = load_sel. All are combinational mux outputs of the held request.
  - At the closing edge: the memory performs the write if load_sel = 1; out_sel <= mem_out; ack_sel <= 1; last <= sel; next state = IDLE.
  - For a write, out_sel captures mem_out at the pre-write address contents (the old word).
- Idle outputs: mem_load = 0, mem_address = 0, mem_in = 0 in IDLE.
- Handshake rules:
  - A requester holds req, load, address and in stable from assertion until it sees ack.
  - ack is high for exactly one cycle.
  - The requester must drop req during ack, or present a new request; a new request is not sampled until the cycle after ack.
  - Only out_sel and ack_sel update on completion; the other requester's out holds.
- Latency and throughput:
  - req sampled in IDLE at cycle t -> BUSY at t+1 -> ack (with out valid) at t+2.
  - Peak throughput is one access per 2 cycles.
  - Under continuous contention with FIXED_PRI = 0, grants alternate 0,1,0,1.
  - With FIXED_PRI = 1, requester 1 can starve; this is accepted behaviour.
- Simultaneous events: ack_i (for the previous owner) and BUSY(j) for the other requester can coincide. Requester i's own re-request in its ack cycle is ignored.
- Request withdrawal: dropping req while in BUSY is a protocol violation. The access still completes and ack is still issued.
- Reset mid-operation:
  - Asserting reset during BUSY aborts the access: mem_load falls asynchronously before the edge, so no write occurs, and no ack is issued.
  - After release, pending reqs re-arbitrate from the reset priority.
- Width rules: no arithmetic. Addresses pass through unmodified; there is no wrap or truncation inside the block.

Test Plan:
- Single write then read: req0 write address0 = 0x0123, in0 = 0xBEEF; then a read of 0x0123 -> ack0 at t+2 for each access; the read returns out0 = 0xBEEF; mem_load is high only in the write's BUSY cycle.
- Contention with FIXED_PRI = 0: after reset, both reqs held for 4 accesses (reads of 0x0001/0x0002) -> grant sequence 01,10,01,10; ack alternates; out values match the preloaded words.
- Contention with FIXED_PRI = 1: req0 re-asserts immediately after each ack, req1 held -> requester 1 is granted only in the cycles where req0 is ineligible (its ack cycle).
- Read-during-write ordering: a write of 0x1234 to 0x3FFF returns the old contents in out1; a following read of 0x3FFF returns 0x1234.
- Reset in BUSY: reset pulsed mid-cycle while BUSY with load0 = 1, address 0x0010, in 0xAAAA -> no ack0; the word at 0x0010 is unchanged; grant = 00, out0 = 0.
- Idle quiet: no reqs for 10 cycles -> grant = 00, mem_load = 0, mem_address = 0, acks = 0 throughout.

Source files
------------

// File: rtl/ram_arbiter2.sv
// Two-requester arbiter sharing one single-port RAM with a combinational read.
// Each granted access takes one BUSY cycle and is acknowledged with registered read data.
module ram_arbiter2 #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 16,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              load0,
  input  logic [ADDR_W-1:0] address0,
  input  logic [DATA_W-1:0] in0,
  output logic              ack0,
  output logic [DATA_W-1:0] out0,
  input  logic              req1,
  input  logic              load1,
  input  logic [ADDR_W-1:0] address1,
  input  logic [DATA_W-1:0] in1,
  output logic              ack1,
  output logic [DATA_W-1:0] out1,
  output logic [1:0]        grant,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy0,
    StBusy1
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic [DATA_W-1:0] out1_q, out1_d;

  logic elig0, elig1;

  // A requester is deaf in the cycle its own ack is high.
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    out0_d  = out0_q;
    out1_d  = out1_q;
    unique case (state_q)
      StIdle: begin
        if (elig0 && elig1) begin
          // Round-robin hands the tie to whoever did not win last time.
          if (FIXED_PRI || last_q) begin
            state_d = StBusy0;
          end else begin
            state_d = StBusy1;
          end
        end else if (elig0) begin
          state_d = StBusy0;
        end else if (elig1) begin
          state_d = StBusy1;
        end
      end
      StBusy0: begin
        state_d = StIdle;
        ack0_d  = 1'b1;
        out0_d  = mem_out;
        last_d  = 1'b0;
      end
      StBusy1: begin
        state_d = StIdle;
        ack1_d  = 1'b1;
        out1_d  = mem_out;
        last_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  // Memory port is a pure function of state, so reset kills a pending write at once.
  always_comb begin
    grant       = 2'b00;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    unique case (state_q)
      StBusy0: begin
        grant       = 2'b01;
        mem_load    = load0;
        mem_address = address0;
        mem_in      = in0;
      end
      StBusy1: begin
        grant       = 2'b10;
        mem_load    = load1;
        mem_address = address1;
        mem_in      = in1;
      end
      default: ;
    endcase
  end

  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign out0 = out0_q;
  assign out1 = out1_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed bench driving a round-robin and a fixed-priority arbiter with identical
// stimulus, each in front of its own behavioural RAM.
module tb_ram_arbiter2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, load0 = 1'b0, req1 = 1'b0, load1 = 1'b0;
  logic [13:0] address0 = '0, address1 = '0;
  logic [15:0] in0 = '0, in1 = '0;

  logic        rr_ack0, rr_ack1, rr_mem_load;
  logic [15:0] rr_out0, rr_out1, rr_mem_in, rr_mem_out;
  logic [13:0] rr_mem_address;
  logic [1:0]  rr_grant;
  logic        fp_ack0, fp_ack1, fp_mem_load;
  logic [15:0] fp_out0, fp_out1, fp_mem_in, fp_mem_out;
  logic [13:0] fp_mem_address;
  logic [1:0]  fp_grant;

  logic [15:0] mem_rr [16384];
  logic [15:0] mem_fp [16384];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_arbiter2 #(.ADDR_W(14), .DATA_W(16), .FIXED_PRI(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .load0(load0), .address0(address0), .in0(in0), .ack0(rr_ack0), .out0(rr_out0),
    .req1(req1), .load1(load1), .address1(address1), .in1(in1), .ack1(rr_ack1), .out1(rr_out1),
    .grant(rr_grant), .mem_load(rr_mem_load), .mem_address(rr_mem_address),
    .mem_in(rr_mem_in), .mem_out(rr_mem_out)
  );

  ram_arbiter2 #(.ADDR_W(14), .DATA_W(16), .FIXED_PRI(1'b1)) u_fp (
    .clock(clock), .reset(reset),
    .req0(req0), .load0(load0), .address0(address0), .in0(in0), .ack0(fp_ack0), .out0(fp_out0),
    .req1(req1), .load1(load1), .address1(address1), .in1(in1), .ack1(fp_ack1), .out1(fp_out1),
    .grant(fp_grant), .mem_load(fp_mem_load), .mem_address(fp_mem_address),
    .mem_in(fp_mem_in), .mem_out(fp_mem_out)
  );

  assign rr_mem_out = mem_rr[rr_mem_address];
  assign fp_mem_out = mem_fp[fp_mem_address];

  always @(posedge clock) begin
    if (rr_mem_load) mem_rr[rr_mem_address] <= rr_mem_in;
    if (fp_mem_load) mem_fp[fp_mem_address] <= fp_mem_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drop_reqs();
    req0  = 1'b0;
    req1  = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [15:0] d);
    mem_rr[a] = d;
    mem_fp[a] = d;
  endtask

  initial begin
    preload(14'h0001, 16'h1111);
    preload(14'h0002, 16'h2222);
    preload(14'h0123, 16'hCAFE);
    preload(14'h3FFF, 16'h0BAD);
    preload(14'h0010, 16'h7777);

    // Reset values while reset is held
    #2;
    check_eq("rst_grant", 32'(rr_grant), 32'h0);
    check_eq("rst_acks", {30'h0, rr_ack1, rr_ack0}, 32'h0);
    check_eq("rst_out0", 32'(rr_out0), 32'h0);
    check_eq("rst_out1", 32'(rr_out1), 32'h0);
    check_eq("rst_mem_load", 32'(rr_mem_load), 32'h0);
    check_eq("rst_mem_addr", 32'(rr_mem_address), 32'h0);
    check_eq("rst_mem_in", 32'(rr_mem_in), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Single write then read by requester 0
    req0 = 1'b1; load0 = 1'b1; address0 = 14'h0123; in0 = 16'hBEEF;
    tick();
    check_eq("wr_grant", 32'(rr_grant), 32'h1);
    check_eq("wr_mem_load", 32'(rr_mem_load), 32'h1);
    check_eq("wr_mem_addr", 32'(rr_mem_address), 32'h0123);
    check_eq("wr_mem_in", 32'(rr_mem_in), 32'hBEEF);
    check_eq("wr_ack_early", 32'(rr_ack0), 32'h0);
    tick();
    check_eq("wr_ack", 32'(rr_ack0), 32'h1);
    check_eq("wr_old_word", 32'(rr_out0), 32'hCAFE);
    check_eq("wr_idle_load", 32'(rr_mem_load), 32'h0);
    check_eq("wr_ram", 32'(mem_rr[14'h0123]), 32'hBEEF);
    load0 = 1'b0;  // new read presented during ack: must wait a cycle
    tick();
    check_eq("rd_ignored_grant", 32'(rr_grant), 32'h0);
    check_eq("rd_ack_pulse", 32'(rr_ack0), 32'h0);
    tick();
    check_eq("rd_grant", 32'(rr_grant), 32'h1);
    check_eq("rd_mem_load", 32'(rr_mem_load), 32'h0);
    tick();
    check_eq("rd_ack", 32'(rr_ack0), 32'h1);
    check_eq("rd_out0", 32'(rr_out0), 32'hBEEF);
    drop_reqs();
    tick();

    // Continuous contention from reset priority: both variants alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; address0 = 14'h0001;
    req1 = 1'b1; address1 = 14'h0002;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rr_cont_grant%0d", k), 32'(rr_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("fp_cont_grant%0d", k), 32'(fp_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check_eq($sformatf("rr_cont_ack%0d", k), {30'h0, rr_ack1, rr_ack0},
               (k % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("rr_cont_out0_%0d", k), 32'(rr_out0), 32'h1111);
      check_eq($sformatf("rr_cont_out1_%0d", k), 32'(rr_out1), (k == 0) ? 32'h0 : 32'h2222);
    end
    drop_reqs();
    tick();

    // Tie after requester 0 won last: round-robin gives 1, fixed priority gives 0
    do_reset();
    req0 = 1'b1; address0 = 14'h0001;
    tick();
    tick();
    drop_reqs();
    tick();
    req0 = 1'b1; req1 = 1'b1; address0 = 14'h0001; address1 = 14'h0002;
    tick();
    check_eq("rr_tie_grant", 32'(rr_grant), 32'h2);
    check_eq("fp_tie_grant", 32'(fp_grant), 32'h1);
    tick();
    check_eq("rr_tie_ack", {30'h0, rr_ack1, rr_ack0}, 32'h2);
    check_eq("fp_tie_ack", {30'h0, fp_ack1, fp_ack0}, 32'h1);
    check_eq("rr_tie_out1", 32'(rr_out1), 32'h2222);
    tick();
    // Fixed priority: requester 1 only gets in while requester 0 is in its ack cycle
    check_eq("fp_starve_grant", 32'(fp_grant), 32'h2);
    check_eq("rr_next_grant", 32'(rr_grant), 32'h1);
    drop_reqs();
    tick();
    tick();

    // Read-during-write ordering on requester 1 at the top address
    do_reset();
    req1 = 1'b1; load1 = 1'b1; address1 = 14'h3FFF; in1 = 16'h1234;
    tick();
    check_eq("rdw_grant", 32'(rr_grant), 32'h2);
    check_eq("rdw_mem_addr", 32'(rr_mem_address), 32'h3FFF);
    tick();
    check_eq("rdw_old", 32'(rr_out1), 32'h0BAD);
    check_eq("rdw_out0_hold", 32'(rr_out0), 32'h0);
    load1 = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rdw_ack", 32'(rr_ack1), 32'h1);
    check_eq("rdw_new", 32'(rr_out1), 32'h1234);
    drop_reqs();
    tick();

    // Reset pulsed mid-cycle during a BUSY write
    do_reset();
    req0 = 1'b1; load0 = 1'b1; address0 = 14'h0010; in0 = 16'hAAAA;
    tick();
    check_eq("abort_busy_load", 32'(rr_mem_load), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_load_async", 32'(rr_mem_load), 32'h0);
    check_eq("abort_grant_async", 32'(rr_grant), 32'h0);
    tick();
    drop_reqs();
    reset = 1'b0;
    tick();
    check_eq("abort_ack", 32'(rr_ack0), 32'h0);
    check_eq("abort_grant", 32'(rr_grant), 32'h0);
    check_eq("abort_out0", 32'(rr_out0), 32'h0);
    check_eq("abort_ram", 32'(mem_rr[14'h0010]), 32'h7777);

    // Idle quiet
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("idle_grant%0d", k), 32'(rr_grant), 32'h0);
      check_eq($sformatf("idle_load%0d", k), 32'(rr_mem_load), 32'h0);
      check_eq($sformatf("idle_addr%0d", k), 32'(rr_mem_address), 32'h0);
      check_eq($sformatf("idle_acks%0d", k), {30'h0, rr_ack1, rr_ack0}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
